// File: rtl/svc_rv_scoreboard_if.sv
// Handshake bundle between the ID/completion logic and the register scoreboard.
// The master modport is the pipeline side; the slave modport is the scoreboard.
interface svc_rv_scoreboard_if #(
   parameter int NREGS   = 32,
   parameter int MAX_OUT = 4
) ();
   localparam int RW = $clog2(NREGS);
   localparam int OW = $clog2(MAX_OUT + 1);

   logic          issue_valid;
   logic [RW-1:0] issue_rd;
   logic          issue_ready;
   logic          cmpl_valid;
   logic [RW-1:0] cmpl_rd;
   logic [RW-1:0] rs1_id;
   logic [RW-1:0] rs2_id;
   logic          rs1_used_id;
   logic          rs2_used_id;
   logic          hazard_rs1;
   logic          hazard_rs2;
   logic          stall;
   logic          busy;
   logic [OW-1:0] outstanding;
   logic          err;

   modport master (
      output issue_valid, issue_rd, cmpl_valid, cmpl_rd,
             rs1_id, rs2_id, rs1_used_id, rs2_used_id,
      input  issue_ready, hazard_rs1, hazard_rs2, stall, busy, outstanding, err
   );

   modport slave (
      input  issue_valid, issue_rd, cmpl_valid, cmpl_rd,
             rs1_id, rs2_id, rs1_used_id, rs2_used_id,
      output issue_ready, hazard_rs1, hazard_rs2, stall, busy, outstanding, err
   );
endinterface

// File: rtl/svc_rv_scoreboard.sv
// Register scoreboard: per-register pending-writer counts for variable-latency producers,
// stalling ID readers of pending registers and backpressuring issue at capacity.
module svc_rv_scoreboard #(
   parameter int NREGS   = 32,
   parameter int CNT_W   = 2,
   parameter int MAX_OUT = 4,
   parameter bit BYPASS  = 1'b1
) (
   input logic                clk,
   input logic                rst,
   svc_rv_scoreboard_if.slave sb
);
   localparam int RW = $clog2(NREGS);
   localparam int OW = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [RW-1:0]    RD_ZERO  = {RW{1'b0}};
   localparam logic [OW-1:0]    TOT_ZERO = {OW{1'b0}};
   localparam logic [OW-1:0]    TOT_FULL = OW'(MAX_OUT);

   logic [CNT_W-1:0] r_cnt [NREGS];
   logic [OW-1:0]    r_tot;
   logic             r_err;

   logic [CNT_W-1:0] w_issue_cnt;
   logic [CNT_W-1:0] w_cmpl_cnt;
   logic             w_cmpl_fire;
   logic             w_cmpl_dec;
   logic             w_tot_dec;
   logic             w_underflow;
   logic             w_issue_ready;
   logic             w_issue_fire;

   // A retiring last writer may release its reader in the same cycle when BYPASS is set.
   function automatic logic f_hazard(input logic             used,
                                     input logic [RW-1:0]    rs,
                                     input logic [CNT_W-1:0] cnt,
                                     input logic             cmpl_fire,
                                     input logic [RW-1:0]    cmpl_rd);
      logic bypass_hit;
      bypass_hit = BYPASS && cmpl_fire && (cmpl_rd == rs) && (cnt == CNT_W'(1));
      return used && (rs != RD_ZERO) && (cnt != CNT_ZERO) && !bypass_hit;
   endfunction

   always_comb begin
      w_issue_cnt = r_cnt[sb.issue_rd];
      w_cmpl_cnt  = r_cnt[sb.cmpl_rd];
      w_cmpl_fire = sb.cmpl_valid && (sb.cmpl_rd != RD_ZERO);
      w_cmpl_dec  = w_cmpl_fire && (w_cmpl_cnt != CNT_ZERO);
      w_tot_dec   = w_cmpl_fire && (r_tot != TOT_ZERO);
      w_underflow = w_cmpl_fire && ((w_cmpl_cnt == CNT_ZERO) || (r_tot == TOT_ZERO));
      // A same-cycle completion frees a global slot but never a per-register one.
      if (sb.issue_rd == RD_ZERO) begin
         w_issue_ready = 1'b1;
      end else if (w_issue_cnt == CNT_MAX) begin
         w_issue_ready = 1'b0;
      end else if ((r_tot == TOT_FULL) && !w_cmpl_fire) begin
         w_issue_ready = 1'b0;
      end else begin
         w_issue_ready = 1'b1;
      end
      w_issue_fire = sb.issue_valid && w_issue_ready && (sb.issue_rd != RD_ZERO);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            r_cnt[r] <= CNT_ZERO;
         end
         r_tot <= TOT_ZERO;
         r_err <= 1'b0;
      end else begin
         r_cnt[0] <= CNT_ZERO;
         for (int r = 1; r < NREGS; r++) begin
            if (w_issue_fire && (sb.issue_rd == RW'(r)) &&
                !(w_cmpl_dec && (sb.cmpl_rd == RW'(r)))) begin
               r_cnt[r] <= r_cnt[r] + CNT_W'(1);
            end else if (w_cmpl_dec && (sb.cmpl_rd == RW'(r)) &&
                         !(w_issue_fire && (sb.issue_rd == RW'(r)))) begin
               r_cnt[r] <= r_cnt[r] - CNT_W'(1);
            end else begin
               r_cnt[r] <= r_cnt[r];
            end
         end
         r_tot <= r_tot + OW'(w_issue_fire) - OW'(w_tot_dec);
         r_err <= r_err | w_underflow;
      end
   end

   assign sb.issue_ready = w_issue_ready;
   assign sb.hazard_rs1  = f_hazard(sb.rs1_used_id, sb.rs1_id, r_cnt[sb.rs1_id],
                                    w_cmpl_fire, sb.cmpl_rd);
   assign sb.hazard_rs2  = f_hazard(sb.rs2_used_id, sb.rs2_id, r_cnt[sb.rs2_id],
                                    w_cmpl_fire, sb.cmpl_rd);
   assign sb.stall       = sb.hazard_rs1 | sb.hazard_rs2;
   assign sb.busy        = (r_tot != TOT_ZERO);
   assign sb.outstanding = r_tot;
   assign sb.err         = r_err;
endmodule

// File: tb/tb_svc_rv_scoreboard.sv
// Bench for svc_rv_scoreboard: directed vector table, a mid-operation reset sequence,
// and randomized traffic checked against a queue-of-pending-writers reference model.
module tb_svc_rv_scoreboard;
   localparam int NREGS   = 32;
   localparam int MAX_OUT = 4;
   localparam int CNT_MAX = 3;
   localparam int NVEC    = 38;
   localparam int NRAND   = 600;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   svc_rv_scoreboard_if #(.NREGS(NREGS), .MAX_OUT(MAX_OUT)) sb_if ();

   svc_rv_scoreboard #(.NREGS(NREGS), .CNT_W(2), .MAX_OUT(MAX_OUT), .BYPASS(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if.slave)
   );

   typedef struct {
      logic iv; int ird; logic cv; int crd;
      int rs1; int rs2; logic u1; logic u2;
      logic e_rdy; logic e_h1; logic e_h2; int e_out; logic e_err;
   } vec_t;

   vec_t tbl [NVEC];
   int   pend [$];
   int   m_tot;
   bit   m_err;

   function automatic vec_t mk(logic iv, int ird, logic cv, int crd, int rs1, int rs2,
                               logic u1, logic u2, logic rdy, logic h1, logic h2,
                               int o, logic e);
      vec_t v;
      v.iv = iv; v.ird = ird; v.cv = cv; v.crd = crd;
      v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
      v.e_rdy = rdy; v.e_h1 = h1; v.e_h2 = h2; v.e_out = o; v.e_err = e;
      return v;
   endfunction

   task automatic drive(logic iv, int ird, logic cv, int crd, int rs1, int rs2,
                        logic u1, logic u2);
      sb_if.issue_valid = iv;
      sb_if.issue_rd    = 5'(ird);
      sb_if.cmpl_valid  = cv;
      sb_if.cmpl_rd     = 5'(crd);
      sb_if.rs1_id      = 5'(rs1);
      sb_if.rs2_id      = 5'(rs2);
      sb_if.rs1_used_id = u1;
      sb_if.rs2_used_id = u2;
   endtask

   task automatic chk(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic chk_all(string tag, logic rdy, logic h1, logic h2, int o, logic e);
      chk({tag, ".ready"},       int'(sb_if.issue_ready), int'(rdy));
      chk({tag, ".hazard_rs1"},  int'(sb_if.hazard_rs1),  int'(h1));
      chk({tag, ".hazard_rs2"},  int'(sb_if.hazard_rs2),  int'(h2));
      chk({tag, ".stall"},       int'(sb_if.stall),       int'(h1 | h2));
      chk({tag, ".busy"},        int'(sb_if.busy),        int'(o != 0));
      chk({tag, ".outstanding"}, int'(sb_if.outstanding), o);
      chk({tag, ".err"},         int'(sb_if.err),         int'(e));
   endtask

   function automatic int pend_cnt(int rd);
      int n = 0;
      foreach (pend[k]) if (pend[k] == rd) n++;
      return n;
   endfunction

   function automatic logic m_hazard(logic used, int rs, logic cfire, int crd);
      int n = pend_cnt(rs);
      return used && (rs != 0) && (n > 0) && !(cfire && (crd == rs) && (n == 1));
   endfunction

   initial begin
      // iv ird cv crd rs1 rs2 u1 u2 | rdy h1 h2 out err
      tbl[0]  = mk(0,0, 0,0,  5,0,1,0, 1,0,0,0,0);
      tbl[1]  = mk(1,5, 0,0,  5,0,1,0, 1,0,0,0,0);
      tbl[2]  = mk(0,0, 0,0,  5,0,1,0, 1,1,0,1,0);
      tbl[3]  = mk(0,0, 0,0,  5,5,0,1, 1,0,1,1,0);
      tbl[4]  = mk(0,0, 1,5,  5,0,1,0, 1,0,0,1,0);
      tbl[5]  = mk(0,0, 0,0,  5,0,1,0, 1,0,0,0,0);
      tbl[6]  = mk(1,7, 0,0,  0,0,0,0, 1,0,0,0,0);
      tbl[7]  = mk(1,7, 0,0,  0,0,0,0, 1,0,0,1,0);
      tbl[8]  = mk(1,7, 0,0,  0,0,0,0, 1,0,0,2,0);
      tbl[9]  = mk(1,7, 0,0,  7,0,1,0, 0,1,0,3,0);
      tbl[10] = mk(1,8, 0,0,  7,0,1,0, 1,1,0,3,0);
      tbl[11] = mk(1,7, 1,7,  7,0,1,0, 0,1,0,4,0);
      tbl[12] = mk(0,0, 1,7,  7,0,1,0, 1,1,0,3,0);
      tbl[13] = mk(0,0, 1,7,  7,0,1,0, 1,0,0,2,0);
      tbl[14] = mk(0,0, 1,8,  7,0,1,0, 1,0,0,1,0);
      tbl[15] = mk(0,0, 0,0,  0,0,0,0, 1,0,0,0,0);
      tbl[16] = mk(1,1, 0,0,  0,0,0,0, 1,0,0,0,0);
      tbl[17] = mk(1,2, 0,0,  0,0,0,0, 1,0,0,1,0);
      tbl[18] = mk(1,3, 0,0,  0,0,0,0, 1,0,0,2,0);
      tbl[19] = mk(1,4, 0,0,  0,0,0,0, 1,0,0,3,0);
      tbl[20] = mk(1,6, 0,0,  0,0,0,0, 0,0,0,4,0);
      tbl[21] = mk(1,6, 1,1,  0,0,0,0, 1,0,0,4,0);
      tbl[22] = mk(0,0, 0,0,  6,1,1,1, 1,1,0,4,0);
      tbl[23] = mk(0,0, 1,2,  0,0,0,0, 1,0,0,4,0);
      tbl[24] = mk(0,0, 1,3,  0,0,0,0, 1,0,0,3,0);
      tbl[25] = mk(0,0, 1,4,  0,0,0,0, 1,0,0,2,0);
      tbl[26] = mk(0,0, 1,6,  0,0,0,0, 1,0,0,1,0);
      tbl[27] = mk(0,0, 0,0,  0,0,0,0, 1,0,0,0,0);
      tbl[28] = mk(1,9, 0,0,  0,0,0,0, 1,0,0,0,0);
      tbl[29] = mk(1,9, 1,9,  9,0,1,0, 1,0,0,1,0);
      tbl[30] = mk(0,0, 0,0,  9,0,1,0, 1,1,0,1,0);
      tbl[31] = mk(1,0, 0,0,  0,0,1,1, 1,0,0,1,0);
      tbl[32] = mk(0,0, 1,9,  9,0,1,0, 1,0,0,1,0);
      tbl[33] = mk(0,0, 0,0,  0,0,0,0, 1,0,0,0,0);
      tbl[34] = mk(0,0, 1,12, 12,0,1,0, 1,0,0,0,0);
      tbl[35] = mk(1,3, 0,0,  0,0,0,0, 1,0,0,0,1);
      tbl[36] = mk(0,0, 1,3,  3,0,1,0, 1,0,0,1,1);
      tbl[37] = mk(0,0, 0,0,  0,0,0,0, 1,0,0,0,1);

      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_all("reset", 1'b1, 1'b0, 1'b0, 0, 1'b0);

      for (int i = 0; i < NVEC; i++) begin
         @(posedge clk);
         #1;
         drive(tbl[i].iv, tbl[i].ird, tbl[i].cv, tbl[i].crd,
               tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2);
         @(negedge clk);
         chk_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_h1, tbl[i].e_h2,
                 tbl[i].e_out, tbl[i].e_err);
      end

      // Three writers in flight, then reset: tracking and the sticky error are discarded.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 drive(1, 10 + i, 0, 0, 0, 0, 0, 0);
      end
      @(posedge clk);
      #1 drive(0, 0, 0, 0, 10, 12, 1, 1);
      @(negedge clk);
      chk_all("pre_rst", 1'b1, 1'b1, 1'b1, 3, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_all("post_rst", 1'b1, 1'b0, 1'b0, 0, 1'b0);

      pend.delete();
      m_tot = 0;
      m_err = 1'b0;
      for (int c = 0; c < NRAND; c++) begin
         logic iv, cv, u1, u2, cfire, ifire, e_rdy;
         int   ird, crd, rs1, rs2, n_rd, idx;
         bit   found;
         @(posedge clk);
         #1;
         iv  = ($urandom_range(0, 2) != 0);
         ird = $urandom_range(0, 7);
         cv  = 1'b0;
         crd = 0;
         if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
            cv  = 1'b1;
            crd = pend[$urandom_range(0, pend.size() - 1)];
         end else if ($urandom_range(0, 9) == 0) begin
            cv  = 1'b1;
            crd = 0;
         end
         rs1 = $urandom_range(0, 7);
         rs2 = $urandom_range(0, 7);
         u1  = $urandom_range(0, 1);
         u2  = $urandom_range(0, 1);
         drive(iv, ird, cv, crd, rs1, rs2, u1, u2);

         cfire = cv && (crd != 0);
         n_rd  = pend_cnt(ird);
         e_rdy = (ird == 0) || ((n_rd < CNT_MAX) && ((m_tot < MAX_OUT) || cfire));
         @(negedge clk);
         chk_all($sformatf("rnd%0d", c), e_rdy, m_hazard(u1, rs1, cfire, crd),
                 m_hazard(u2, rs2, cfire, crd), m_tot, m_err);

         ifire = iv && e_rdy && (ird != 0);
         if (cfire) begin
            found = 1'b0;
            idx   = -1;
            foreach (pend[k]) if (!found && pend[k] == crd) begin
               found = 1'b1;
               idx   = k;
            end
            if (found) pend.delete(idx);
            else m_err = 1'b1;
            if (m_tot > 0) m_tot--;
         end
         if (ifire) begin
            pend.push_back(ird);
            m_tot++;
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/svc_rv_scoreboard.md
Name: svc_rv_scoreboard

Overview:
- Register scoreboard hazard unit for the RV pipeline.
- Successor to the fixed-stage comparator hazard detector: it handles variable-latency producers (multi-cycle M-ext, non-fixed-latency loads, CSR) by tracking a per-register pending count.
- The ID stage issues long-latency writers; the completion port retires them.
- ID consumers of pending registers stall, and issue is backpressured when tracking capacity is exhausted.

Parameters:
- NREGS, 32: number of architectural registers; register index width RW = $clog2(NREGS).
- CNT_W, 2: width of each per-register pending counter; max per-register count = 2^CNT_W-1.
- MAX_OUT, 4: maximum total outstanding tracked ops across all registers (>=1).
- BYPASS, 1: 1 = a completion in the same cycle clears the hazard for the last pending writer; 0 = hazard clears the cycle after.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  ID presents a long-latency writer of issue_rd
- issue_rd  in  RW  destination register of the issuing op
- issue_ready  out  1  scoreboard can accept the issue this cycle
- cmpl_valid  in  1  a tracked op completes (including squashed ops, which still report)
- cmpl_rd  in  RW  destination register of the completing op
- rs1_id  in  RW  ID source register 1
- rs2_id  in  RW  ID source register 2
- rs1_used_id  in  1  rs1 is read by the ID instruction
- rs2_used_id  in  1  rs2 is read by the ID instruction
- hazard_rs1  out  1  rs1 has a pending writer
- hazard_rs2  out  1  rs2 has a pending writer
- stall  out  1  hazard_rs1 | hazard_rs2
- busy  out  1  any op outstanding
- outstanding  out  $clog2(MAX_OUT+1)  total outstanding count
- err  out  1  sticky protocol error

Behaviour:
- State:
  - cnt[r], CNT_W bits, r in 0..NREGS-1.
  - Total counter tot.
  - Sticky err.
  - cnt[0] is hard-wired to 0.
- Reset (rst=1 at a clk edge):
  - All cnt, tot and err go to 0.
  - Outputs after reset: issue_ready=1, hazard_rs1/2=0, stall=0, busy=0, outstanding=0, err=0.
  - Reset mid-operation discards all tracking; completions of pre-reset ops are the caller's responsibility to suppress.
- Issue fire: issue_valid && issue_ready && issue_rd!=0.
  - issue_rd==0 is never tracked; it does not touch tot and always sees issue_ready=1.
- issue_ready (combinational):
  - Low if issue_rd!=0 and cnt[issue_rd]==max.
  - Low if tot==MAX_OUT and no completion fires this cycle.
  - A completion in the same cycle frees its slot for tot only, never for the per-register limit.
- Completion fire: cmpl_valid && cmpl_rd!=0.
  - No ready signal; completions are always accepted.
- Update (registered, 1-cycle latency):
  - cnt[issue_rd] increments on issue fire.
  - cnt[cmpl_rd] decrements on completion fire.
  - Same register on both in one cycle: cnt is unchanged.
  - tot = tot + issue_fire - cmpl_fire.
- Underflow:
  - Completion fire with cnt[cmpl_rd]==0 or tot==0 sets err (sticky until reset).
  - Affected counters stay at 0 and never wrap.
- Hazard (combinational from current state):
  - hazard_rs1 = rs1_used_id && rs1_id!=0 && cnt[rs1_id]!=0 && !(BYPASS && cmpl fire && cmpl_rd==rs1_id && cnt[rs1_id]==1).
  - hazard_rs2 uses the same rule on rs2.
  - A same-cycle issue does not raise a hazard until the next cycle; the ID instruction is older than the issuing op only when the caller orders it so.
- WAW: multiple outstanding writers to one rd are legal up to the per-register max. The hazard stays set until all have completed.
- busy = (tot!=0); outstanding = tot.
- No combinational path from issue_valid to hazard or stall outputs. issue_ready depends combinationally on issue_rd and cmpl_*.

Test Plan:
- Reset, then idle -> issue_ready=1, stall=0, busy=0, outstanding=0, err=0.
- Issue rd=5 at cycle 0; rs1_id=5, rs1_used_id=1 -> hazard_rs1=0 in cycle 0, =1 from cycle 1. Complete rd=5 at cycle 4 -> BYPASS=1: hazard_rs1=0 in cycle 4; BYPASS=0: hazard_rs1=0 from cycle 5. outstanding returns to 0.
- CNT_W=2: issue rd=7 three times -> issue_ready=0 for issue_rd=7 while issue_ready=1 for issue_rd=8. Two completions of rd=7 -> hazard persists. Third completion -> hazard clears.
- MAX_OUT=4: issue rd=1,2,3,4 -> outstanding=4, issue_ready=0. Issue rd=6 together with completion of rd=1 in the same cycle -> accepted, outstanding stays 4.
- Simultaneous issue and completion on rd=9 with cnt=1 -> cnt stays 1 and the hazard remains. rs1_id=0 / issue_rd=0 -> never hazard, never tracked.
- Completion of rd=12 with cnt=0 -> err=1, held through further traffic, cleared only by rst. Assert rst with 3 ops outstanding -> all counters 0 next cycle.
